ram_datapath: RTL and testbench

- 64-bit datapath containing a 32x64 register file, a 5-bit-function ALU and a 4096x64 data RAM.
- Blocks share one tri-state data bus D.
- Control words come from an external control unit, one per cycle; ADDI, ADD/SUB, STUR, LDUR and BR style operations are supported.
- Exposes registers X0..X7, ALU status and a PC-input path for the fetch unit.

---
 rtl/ram_datapath.sv | 214 +++++++++++++++++++++
 tb/tb_ram_datapath.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_datapath.sv
// ram_datapath: 64-bit datapath built around a shared tri-state data bus D.
//
// Contents:
//   - 32 x DW register file: two combinational read ports (A = X[SA],
//     B = X[SB]) and one write port (X[DA] <= D when W=1). Index 31 always
//     reads as zero and is never written. An asynchronous active-low reset
//     clears every register.
//   - 5-bit-function ALU: optional inversion of either operand, then one of
//     AND, OR, ADD (with carry-in), XOR, shift left or logical shift right.
//     Produces the {V,C,N,Z} status flags.
//   - 2^AW x DW data RAM (instance "ram", array "mem"): synchronous write,
//     combinational read. The RAM contents are not reset.
//
// Ports:
//   clk, rst           clock (rising edge) and async active-low reset
//   W, DA, SA, SB      register write enable, destination and read selects
//   K, K_SEL           constant operand and ALU B-input select (1 = K)
//   FS, C0             ALU function select and carry-in
//   EN_ALU, EN_B       drive the ALU result / the B bus onto D
//   EN_ADDR            take the RAM address from F[AW-1:0] (otherwise 0)
//   CS, WE, OE         RAM chip select, write enable, output enable
//   PC_SEL, UNKNOWN    PC_in source select (1 = A bus) and alternate source
//   Status             {V,C,N,Z} of the current ALU result
//   r0..r7             live contents of X0..X7
//   PC_in              next-PC candidate for the fetch unit

module ram_datapath_alu #(
  parameter int unsigned DW = 64
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [4:0]    fs_i,
  input  logic          c0_i,
  output logic [DW-1:0] f_o,
  output logic [3:0]    status_o
);
  localparam int unsigned SHW = $clog2(DW);

  logic [DW-1:0] a_op;
  logic [DW-1:0] b_op;
  logic [DW:0]   sum;
  logic          is_add;
  logic          carry;
  logic          ovf;

  always_comb begin
    a_op   = fs_i[0] ? ~a_i : a_i;
    b_op   = fs_i[1] ? ~b_i : b_i;
    sum    = {1'b0, a_op} + {1'b0, b_op} + {{DW{1'b0}}, c0_i};
    is_add = (fs_i[4:2] == 3'b010);

    f_o = '0;
    unique case (fs_i[4:2])
      3'b000:  f_o = a_op & b_op;
      3'b001:  f_o = a_op | b_op;
      3'b010:  f_o = sum[DW-1:0];
      3'b011:  f_o = a_op ^ b_op;
      3'b100:  f_o = a_op << b_op[SHW-1:0];
      3'b101:  f_o = a_op >> b_op[SHW-1:0];
      default: f_o = '0;
    endcase

    // Carry and overflow only mean something for the add; other ops report 0.
    carry = is_add & sum[DW];
    ovf   = is_add & (a_op[DW-1] == b_op[DW-1]) & (sum[DW-1] != a_op[DW-1]);

    status_o = {ovf, carry, f_o[DW-1], (f_o == '0)};
  end
endmodule

module ram_datapath_ram #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          cs_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (cs_i && we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];
endmodule

module ram_datapath #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          W,
  input  logic [4:0]    DA,
  input  logic [4:0]    SA,
  input  logic [4:0]    SB,
  input  logic [DW-1:0] K,
  input  logic          K_SEL,
  input  logic [4:0]    FS,
  input  logic          C0,
  input  logic          EN_ALU,
  input  logic          EN_B,
  input  logic          EN_ADDR,
  input  logic          CS,
  input  logic          WE,
  input  logic          OE,
  input  logic          PC_SEL,
  input  logic [DW-1:0] UNKNOWN,
  output logic [3:0]    Status,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3,
  output logic [DW-1:0] r4,
  output logic [DW-1:0] r5,
  output logic [DW-1:0] r6,
  output logic [DW-1:0] r7,
  output logic [DW-1:0] PC_in
);
  localparam int unsigned NREG = 32;
  localparam logic [4:0]  XZR  = 5'd31;

  // Shared data bus; the control unit guarantees at most one driver.
  tri [DW-1:0] D;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] a_bus;
  logic [DW-1:0] b_bus;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] F;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] ram_rdata;
  logic          ram_drive;

  // Register file ----------------------------------------------------------
  assign a_bus = (SA == XZR) ? '0 : regs_q[SA];
  assign b_bus = (SB == XZR) ? '0 : regs_q[SB];

  always_comb begin
    regs_d = regs_q;
    if (W && (DA != XZR)) begin
      regs_d[DA] = D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // ALU --------------------------------------------------------------------
  assign alu_b = K_SEL ? K : b_bus;

  ram_datapath_alu #(
    .DW (DW)
  ) u_alu (
    .a_i      (a_bus),
    .b_i      (alu_b),
    .fs_i     (FS),
    .c0_i     (C0),
    .f_o      (F),
    .status_o (Status)
  );

  // F is always live, so loads/stores get reg[SA]+K as address without
  // having to put F on the bus.
  assign ADDR = EN_ADDR ? F[AW-1:0] : '0;

  // Data RAM ---------------------------------------------------------------
  ram_datapath_ram #(
    .DW (DW),
    .AW (AW)
  ) ram (
    .clk_i   (clk),
    .cs_i    (CS),
    .we_i    (WE),
    .addr_i  (ADDR),
    .wdata_i (D),
    .rdata_o (ram_rdata)
  );

  assign ram_drive = CS & OE & ~WE;

  // Bus drivers ------------------------------------------------------------
  assign D = EN_ALU    ? F         : 'z;
  assign D = EN_B      ? b_bus     : 'z;
  assign D = ram_drive ? ram_rdata : 'z;

  // Observation and fetch paths ------------------------------------------------
  assign PC_in = PC_SEL ? a_bus : UNKNOWN;

  assign r0 = regs_q[0];
  assign r1 = regs_q[1];
  assign r2 = regs_q[2];
  assign r3 = regs_q[3];
  assign r4 = regs_q[4];
  assign r5 = regs_q[5];
  assign r6 = regs_q[6];
  assign r7 = regs_q[7];
endmodule

// File: tb/tb_ram_datapath.sv
// Self-checking bench for ram_datapath: directed sequence with literal
// expectations, then randomized control words checked every cycle against a
// behavioural model of registers, RAM and ALU.

module tb_ram_datapath;
  logic        clk = 1'b0;
  logic        rst;
  logic        W, K_SEL, C0, EN_ALU, EN_B, EN_ADDR, CS, WE, OE, PC_SEL;
  logic [4:0]  DA, SA, SB, FS;
  logic [63:0] K, UNKNOWN;
  logic [3:0]  Status;
  logic [63:0] PC_in;
  logic [63:0] rv [8];

  int vectors    = 0;
  int miscompares = 0;
  logic cmp_en = 1'b0;

  // Behavioural model state
  logic [63:0] mregs [32];
  logic [63:0] mmem  [int unsigned];
  int unsigned stored_addrs [$];
  logic        store_pend = 1'b0;
  logic [11:0] store_addr = '0;

  always #5 clk = ~clk;

  ram_datapath #(.DW(64), .AW(12)) dut (
    .clk(clk), .rst(rst), .W(W), .DA(DA), .SA(SA), .SB(SB), .K(K),
    .K_SEL(K_SEL), .FS(FS), .C0(C0), .EN_ALU(EN_ALU), .EN_B(EN_B),
    .EN_ADDR(EN_ADDR), .CS(CS), .WE(WE), .OE(OE), .PC_SEL(PC_SEL),
    .UNKNOWN(UNKNOWN), .Status(Status),
    .r0(rv[0]), .r1(rv[1]), .r2(rv[2]), .r3(rv[3]),
    .r4(rv[4]), .r5(rv[5]), .r6(rv[6]), .r7(rv[7]),
    .PC_in(PC_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {V,C,N,Z,F}; operation chosen by the spec's FS rules.
  function automatic logic [67:0] model_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] fs, input logic c0);
    logic [63:0] x, y, f;
    logic        c, v;
    logic [64:0] u;
    logic signed [65:0] s;
    x = fs[0] ? ~a : a;
    y = fs[1] ? ~b : b;
    c = 1'b0;
    v = 1'b0;
    f = 64'd0;
    case (fs[4:2])
      3'd0: f = x & y;
      3'd1: f = x | y;
      3'd2: begin
        u = 65'(x) + 65'(y) + 65'(c0);
        f = u[63:0];
        c = u[64];
        s = $signed({x[63], x[63], x}) + $signed({y[63], y[63], y}) + $signed({65'd0, c0});
        v = (s != $signed({f[63], f[63], f}));
      end
      3'd3: f = x ^ y;
      3'd4: f = x << y[5:0];
      3'd5: f = x >> y[5:0];
      default: f = 64'd0;
    endcase
    return {v, c, f[63], (f == 64'd0), f};
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] idx);
    return (idx == 5'd31) ? 64'd0 : mregs[idx];
  endfunction

  function automatic logic [67:0] m_comb();
    return model_alu(m_read(SA), K_SEL ? K : m_read(SB), FS, C0);
  endfunction

  // Model state update at each clock edge / async reset
  always @(posedge clk or negedge rst) begin
    logic [67:0] res;
    logic [11:0] addr;
    logic [63:0] d;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      store_pend = 1'b0;
    end else begin
      res  = m_comb();
      addr = EN_ADDR ? res[11:0] : 12'd0;
      d    = 'x;
      if (EN_ALU) d = res[63:0];
      else if (EN_B) d = m_read(SB);
      else if (CS && OE && !WE && mmem.exists(int'(addr))) d = mmem[int'(addr)];
      if (W && DA != 5'd31) mregs[DA] = d;
      store_pend = 1'b0;
      if (CS && WE) begin
        if (!mmem.exists(int'(addr))) stored_addrs.push_back(int'(addr));
        mmem[int'(addr)] = d;
        store_pend = 1'b1;
        store_addr = addr;
      end
    end
  end

  // Compare process: outputs are stable mid-cycle
  always @(negedge clk) begin
    logic [67:0] res;
    if (cmp_en) begin
      res = m_comb();
      for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), rv[i], mregs[i]);
      chk("Status", {60'd0, Status}, {60'd0, res[67:64]});
      chk("PC_in", PC_in, PC_SEL ? m_read(SA) : UNKNOWN);
      if (store_pend) chk("mem", dut.ram.mem[store_addr], mmem[int'(store_addr)]);
    end
  end

  task automatic idle();
    W = 0; DA = 0; SA = 0; SB = 0; K = 0; K_SEL = 0; FS = 0; C0 = 0;
    EN_ALU = 0; EN_B = 0; EN_ADDR = 0; CS = 0; WE = 0; OE = 0;
    PC_SEL = 0; UNKNOWN = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic random_cycle();
    int kind;
    idle();
    PC_SEL  = 1'($urandom_range(0, 1));
    UNKNOWN = rand64();
    SA = 5'($urandom); SB = 5'($urandom); DA = 5'($urandom);
    kind = $urandom_range(0, 9);
    if (kind >= 7 && kind <= 8 && stored_addrs.size() == 0) kind = 0;
    if (kind <= 4) begin
      K = rand64(); K_SEL = 1'($urandom_range(0, 1));
      FS = 5'($urandom); C0 = 1'($urandom_range(0, 1));
      EN_ALU = 1; W = 1;
    end else if (kind <= 6) begin
      K = rand64(); K_SEL = 1; FS = 5'b01000;
      EN_B = 1; EN_ADDR = 1; CS = 1; WE = 1;
    end else if (kind <= 8) begin
      SA = 5'd31; K_SEL = 1; FS = 5'b01000;
      K = {52'($urandom) , 12'(stored_addrs[$urandom_range(0, stored_addrs.size() - 1)])};
      EN_ADDR = 1; CS = 1; OE = 1; W = 1;
    end else begin
      EN_B = 1'($urandom_range(0, 1)); K = rand64(); FS = 5'($urandom);
    end
    tick();
  endtask

  logic [63:0] addi_k [4] = '{64'h0000FFFF0000000F, 64'hFFFF0000000000F0,
                              64'h0123456789ABCDEF, 64'hCCCCCCCCCCCCCCCC};
  logic [63:0] final_r [8] = '{64'h0000FFFF0000000F, 64'hFFFF0000000000F0,
                               64'h0123456789ABCDEF, 64'hCCCCCCCCCCCCCCCC,
                               64'hFFFF0000000000F1, 64'h0,
                               64'h0123456789ABCDEF, 64'hCCCCCCCCCCCCCCCC};

  initial begin
    idle();
    rst = 1;
    #2 rst = 0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reset_r%0d", i), rv[i], 64'd0);
    tick();
    rst = 1;
    cmp_en = 1;

    // ADDI into X0..X3
    for (int i = 0; i < 4; i++) begin
      idle();
      SA = 31; K_SEL = 1; FS = 5'b01000; EN_ALU = 1; W = 1;
      K = addi_k[i]; DA = 5'(i);
      tick();
      chk($sformatf("addi_r%0d", i), rv[i], addi_k[i]);
    end

    // SUB: X4 = X1 - all-ones
    idle();
    SA = 1; K_SEL = 1; K = '1; FS = 5'b01010; C0 = 1; EN_ALU = 1; W = 1; DA = 4;
    #1 chk("sub_status", {60'd0, Status}, 64'h2);
    tick();
    chk("sub_r4", rv[4], 64'hFFFF0000000000F1);

    // Stores
    idle();
    SA = 0; SB = 2; K_SEL = 1; FS = 5'b01000; EN_B = 1; EN_ADDR = 1; CS = 1; WE = 1;
    tick();
    chk("store_00F", dut.ram.mem[12'h00F], 64'h0123456789ABCDEF);
    SA = 1; SB = 3;
    tick();
    chk("store_0F0", dut.ram.mem[12'h0F0], 64'hCCCCCCCCCCCCCCCC);

    // Loads
    idle();
    SA = 0; K_SEL = 1; FS = 5'b01000; EN_ADDR = 1; CS = 1; OE = 1; W = 1; DA = 6;
    tick();
    chk("load_r6", rv[6], 64'h0123456789ABCDEF);
    SA = 1; DA = 7;
    tick();
    chk("load_r7", rv[7], 64'hCCCCCCCCCCCCCCCC);

    // PC path
    idle();
    PC_SEL = 1; SA = 6;
    #1 chk("pc_a", PC_in, 64'h0123456789ABCDEF);
    PC_SEL = 0; UNKNOWN = 64'hDEADBEEF_0BADF00D;
    #1 chk("pc_unknown", PC_in, 64'hDEADBEEF_0BADF00D);

    // No-write cycle with B on bus
    idle();
    EN_B = 1; SB = 2; DA = 5;
    tick();
    for (int i = 0; i < 8; i++) chk($sformatf("nowrite_r%0d", i), rv[i], final_r[i]);

    // Write to X31 is discarded
    idle();
    SA = 31; K_SEL = 1; K = 64'h55; FS = 5'b01000; EN_ALU = 1; W = 1; DA = 31;
    tick();
    idle();
    SA = 31; PC_SEL = 1;
    #1 chk("x31_zero", PC_in, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) random_cycle();

    // Asynchronous reset mid-cycle clears registers without an edge
    idle();
    #1 rst = 0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("async_rst_r%0d", i), rv[i], 64'd0);
    tick();
    rst = 1;

    for (int n = 0; n < 1500; n++) random_cycle();

    idle();
    tick();
    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
